// File: rtl/handshake_muli_pipe.sv
// handshake_muli_pipe
// Elastic, pipelined, signed fixed-point multiplier. Two valid/ready operand
// channels (lhs sample, rhs coefficient) are joined; the product is rescaled
// by FRAC_BITS and emitted on a single valid/ready result channel after a
// fixed LATENCY of register stages. The whole pipeline advances together
// (no bubble collapsing), so throughput is one token per cycle unless the
// result consumer back-pressures.
//
// Optional feature macro: HANDSHAKE_MULI_SAT_EN
//   defined   -> rescaled value clamps to the signed DATA_WIDTH range
//   undefined -> rescaled value wraps (plain truncation)
module handshake_muli_pipe #(
    parameter int DATA_WIDTH = 24,
    parameter int FRAC_BITS  = 16,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] lhs,
    input  logic                  lhs_valid,
    output logic                  lhs_ready,
    input  logic [DATA_WIDTH-1:0] rhs,
    input  logic                  rhs_valid,
    output logic                  rhs_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid,
    input  logic                  result_ready
);

    localparam int PW = 2 * DATA_WIDTH;

    // Arithmetic shift of the full product by FRAC_BITS, then either wrap to
    // DATA_WIDTH bits or clamp to the signed DATA_WIDTH range.
    function automatic logic [DATA_WIDTH-1:0] rescale(input logic [PW-1:0] prod);
        logic signed [PW-1:0] sh;
        logic signed [PW-1:0] max_v;
        logic signed [PW-1:0] min_v;
        sh    = $signed(prod) >>> FRAC_BITS;
        max_v = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
        min_v = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`ifdef HANDSHAKE_MULI_SAT_EN
        if (sh > max_v) begin
            rescale = DATA_WIDTH'(max_v);
        end else if (sh < min_v) begin
            rescale = DATA_WIDTH'(min_v);
        end else begin
            rescale = DATA_WIDTH'(sh);
        end
`else
        // Bounds are only meaningful when clamping; keep them referenced so
        // both builds share one function body.
        rescale = DATA_WIDTH'(sh) | (DATA_WIDTH'(max_v) & DATA_WIDTH'(min_v));
`endif
    endfunction

    logic [LATENCY-1:0]   v_r;
    logic [PW-1:0]        prod_r;
    logic signed [PW-1:0] mult_s;
    logic                 en_s;
    logic                 fire_s;

    // Global advance enable, join handshake and full-width signed product.
    always_comb begin
        en_s      = 1'b0;
        fire_s    = 1'b0;
        lhs_ready = 1'b0;
        rhs_ready = 1'b0;
        mult_s    = '0;
        en_s      = (!v_r[LATENCY-1]) || result_ready;
        fire_s    = lhs_valid && rhs_valid && en_s;
        lhs_ready = en_s && rhs_valid;
        rhs_ready = en_s && lhs_valid;
        mult_s    = PW'($signed(lhs)) * PW'($signed(rhs));
    end

    // Stage valid bits: stage 0 captures fire, later stages shift on enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_r <= '0;
        end else if (en_s) begin
            v_r[0] <= fire_s;
            for (int i = 1; i < LATENCY; i++) begin
                v_r[i] <= v_r[i-1];
            end
        end
    end

    // Stage 0 data: full product, loaded only when a token is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_r <= '0;
        end else if (fire_s) begin
            prod_r <= mult_s;
        end
    end

    generate
        if (LATENCY > 1) begin : g_multi
            logic [DATA_WIDTH-1:0] data_r [1:LATENCY-1];

            // Rescale between stage 0 and 1 so the result leaves a register.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 1; i < LATENCY; i++) begin
                        data_r[i] <= '0;
                    end
                end else if (en_s) begin
                    data_r[1] <= rescale(prod_r);
                    for (int i = 2; i < LATENCY; i++) begin
                        data_r[i] <= data_r[i-1];
                    end
                end
            end

            assign result = data_r[LATENCY-1];
        end else begin : g_single
            assign result = rescale(prod_r);
        end
    endgenerate

    assign result_valid = v_r[LATENCY-1];

endmodule

// File: tb/tb_handshake_muli_pipe.sv
// Self-checking bench for handshake_muli_pipe (Q8.16, LATENCY 4).
module tb_handshake_muli_pipe;

    localparam int W = 24;
    localparam int F = 16;
    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] lhs, rhs, result;
    logic         lhs_valid, rhs_valid, result_ready;
    logic         lhs_ready, rhs_ready, result_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    handshake_muli_pipe #(.DATA_WIDTH(W), .FRAC_BITS(F), .LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .lhs(lhs), .lhs_valid(lhs_valid), .lhs_ready(lhs_ready),
        .rhs(rhs), .rhs_valid(rhs_valid), .rhs_ready(rhs_ready),
        .result(result), .result_valid(result_valid), .result_ready(result_ready)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: real-number-style product, arithmetic shift, wrap or clamp.
    function automatic logic [W-1:0] model_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, p, q;
        logic [63:0] qb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        q  = p >>> F;
`ifdef HANDSHAKE_MULI_SAT_EN
        if (q > 64'sd8388607)  return 24'h7FFFFF;
        if (q < -64'sd8388608) return 24'h800000;
`endif
        qb = q;
        return qb[W-1:0];
    endfunction

    // Drive one operand pair with result_ready=1; report acceptance,
    // cycles until result_valid and the value shown then.
    task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b,
                            output bit fired, output int lat, output logic [W-1:0] res);
        lhs = a; rhs = b; lhs_valid = 1'b1; rhs_valid = 1'b1; result_ready = 1'b1;
        @(negedge clk);
        fired = lhs_ready && rhs_ready;
        @(posedge clk); #1;
        lhs_valid = 1'b0; rhs_valid = 1'b0;
        lat = -1; res = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (result_valid) begin
                lat = c; res = result;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; lhs = '0; rhs = '0;
        lhs_valid = 1'b0; rhs_valid = 1'b0; result_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", result_valid); end
        checks++;
        if (result !== 24'h000000) begin failures++; $display("FAIL reset_result: got %h want 000000", result); end
        checks++;
        if (lhs_ready !== 1'b0 || rhs_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready: got %b%b want 00", lhs_ready, rhs_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit fired; int lat; logic [W-1:0] res;
        send_one(24'h010000, 24'h020000, fired, lat, res);
        checks++;
        if (fired !== 1'b1) begin failures++; $display("FAIL basic_fire: got %b want 1", fired); end
        checks++;
        if (lat != L) begin failures++; $display("FAIL basic_latency: got %0d want %0d", lat, L); end
        checks++;
        if (res !== 24'h020000) begin failures++; $display("FAIL basic_result: got %h want 020000", res); end
    endtask

    task automatic test_signed();
        bit fired; int lat; logic [W-1:0] res;
        send_one(24'hFF0000, 24'h008000, fired, lat, res);
        checks++;
        if (res !== 24'hFF8000) begin failures++; $display("FAIL signed_neg_half: got %h want ff8000", res); end
        send_one(24'hFF0000, 24'hFF0000, fired, lat, res);
        checks++;
        if (res !== 24'h010000) begin failures++; $display("FAIL signed_neg_neg: got %h want 010000", res); end
        checks++;
        if (lat != L) begin failures++; $display("FAIL signed_latency: got %0d want %0d", lat, L); end
    endtask

    task automatic test_join();
        int outs = 0;
        int bad_ready = 0;
        lhs = 24'h030000; rhs = 24'h010000;
        lhs_valid = 1'b1; rhs_valid = 1'b0; result_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (lhs_ready !== 1'b0 || result_valid !== 1'b0) bad_ready++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad_ready != 0) begin failures++; $display("FAIL join_lone_lhs: got %0d bad cycles want 0", bad_ready); end
        rhs_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (lhs_ready !== 1'b1 || rhs_ready !== 1'b1) begin
            failures++; $display("FAIL join_fire_ready: got %b%b want 11", lhs_ready, rhs_ready);
        end
        @(posedge clk); #1;
        lhs_valid = 1'b0; rhs_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (result_valid) begin
                outs++;
                checks++;
                if (result !== 24'h030000) begin failures++; $display("FAIL join_result: got %h want 030000", result); end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (outs != 1) begin failures++; $display("FAIL join_token_count: got %0d want 1", outs); end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int n = 0;
        int first = -1;
        int last = -1;
        logic [W-1:0] expv;
        result_ready = 1'b0; rhs = 24'h010000;
        for (int c = 0; c < 8; c++) begin
            lhs = 24'((idx + 1) << 16);
            lhs_valid = 1'b1; rhs_valid = 1'b1;
            @(negedge clk);
            if (lhs_ready && rhs_ready) idx++;
            @(posedge clk); #1;
        end
        checks++;
        if (idx != 4) begin failures++; $display("FAIL bp_accepted: got %0d want 4", idx); end
        @(negedge clk);
        checks++;
        if (lhs_ready !== 1'b0 || rhs_ready !== 1'b0) begin
            failures++; $display("FAIL bp_stall_ready: got %b%b want 00", lhs_ready, rhs_ready);
        end
        @(posedge clk); #1;
        result_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            lhs = 24'((idx + 1) << 16);
            lhs_valid = (idx < 5); rhs_valid = (idx < 5);
            @(negedge clk);
            if (lhs_valid && lhs_ready && rhs_ready) idx++;
            if (result_valid) begin
                expv = 24'((n + 1) * 65536);
                checks++;
                if (result !== expv) begin failures++; $display("FAIL bp_drain_order: got %h want %h", result, expv); end
                if (first < 0) first = c;
                last = c;
                n++;
            end
            @(posedge clk); #1;
        end
        lhs_valid = 1'b0; rhs_valid = 1'b0;
        checks++;
        if (n != 5) begin failures++; $display("FAIL bp_drain_count: got %0d want 5", n); end
        checks++;
        if (last - first != 4) begin failures++; $display("FAIL bp_drain_rate: got span %0d want 4", last - first); end
    endtask

    task automatic test_overflow();
        bit fired; int lat; logic [W-1:0] res;
        logic [W-1:0] exp_pos, exp_neg;
`ifdef HANDSHAKE_MULI_SAT_EN
        exp_pos = 24'h7FFFFF; exp_neg = 24'h800000;
`else
        exp_pos = 24'h000000; exp_neg = 24'h000000;
`endif
        send_one(24'h400000, 24'h040000, fired, lat, res);
        checks++;
        if (res !== exp_pos) begin failures++; $display("FAIL overflow_pos: got %h want %h", res, exp_pos); end
        send_one(24'h800000, 24'h020000, fired, lat, res);
        checks++;
        if (res !== exp_neg) begin failures++; $display("FAIL overflow_neg: got %h want %h", res, exp_neg); end
    endtask

    task automatic test_midreset();
        bit fired; int lat; logic [W-1:0] res;
        int acc = 0;
        int stale = 0;
        result_ready = 1'b0; rhs = 24'h010000;
        for (int c = 0; c < 3; c++) begin
            lhs = 24'((c + 1) << 16);
            lhs_valid = 1'b1; rhs_valid = 1'b1;
            @(negedge clk);
            if (lhs_ready && rhs_ready) acc++;
            @(posedge clk); #1;
        end
        lhs_valid = 1'b0; rhs_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (acc != 3) begin failures++; $display("FAIL midrst_accepted: got %0d want 3", acc); end
        checks++;
        if (result_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid: got %b want 1", result_valid); end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (result_valid !== 1'b0) begin failures++; $display("FAIL midrst_async_valid: got %b want 0", result_valid); end
        checks++;
        if (result !== 24'h000000) begin failures++; $display("FAIL midrst_async_result: got %h want 000000", result); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        result_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (result_valid) stale++;
        end
        checks++;
        if (stale != 0) begin failures++; $display("FAIL midrst_stale: got %0d want 0", stale); end
        @(posedge clk); #1;
        send_one(24'h030000, 24'h010000, fired, lat, res);
        checks++;
        if (lat != L) begin failures++; $display("FAIL midrst_latency: got %0d want %0d", lat, L); end
        checks++;
        if (res !== 24'h030000) begin failures++; $display("FAIL midrst_result: got %h want 030000", res); end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_q[$];
        int           cyc_q[$];
        logic [W-1:0] expv;
        logic [31:0]  tmp;
        logic [W-1:0] prev_res = '0;
        bit           prev_stall = 1'b0;
        int           fc;
        int           cyc = 0;
        for (int c = 0; c < 400; c++) begin
            if (c < 360) begin
                tmp = $urandom;
                lhs = ($urandom_range(0, 1) == 0) ? tmp[W-1:0] : {{8{tmp[23]}}, tmp[15:0]};
                tmp = $urandom;
                rhs = ($urandom_range(0, 1) == 0) ? tmp[W-1:0] : {{8{tmp[23]}}, tmp[15:0]};
                lhs_valid = ($urandom_range(0, 3) != 0);
                rhs_valid = ($urandom_range(0, 3) != 0);
                result_ready = ($urandom_range(0, 2) != 0);
            end else begin
                lhs_valid = 1'b0; rhs_valid = 1'b0; result_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                checks++;
                if (result_valid !== 1'b1 || result !== prev_res) begin
                    failures++; $display("FAIL rnd_hold: got %b/%h want 1/%h", result_valid, result, prev_res);
                end
            end
            if (result_valid && !result_ready) begin
                checks++;
                if (lhs_ready !== 1'b0 || rhs_ready !== 1'b0) begin
                    failures++; $display("FAIL rnd_stall_ready: got %b%b want 00", lhs_ready, rhs_ready);
                end
            end
            if (lhs_ready && !rhs_valid) begin
                checks++; failures++;
                $display("FAIL rnd_lone_ready: lhs_ready=1 with rhs_valid=0");
            end
            if (lhs_valid && rhs_valid && lhs_ready && rhs_ready) begin
                exp_q.push_back(model_mul(lhs, rhs));
                cyc_q.push_back(cyc);
            end
            if (result_valid && result_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rnd_unexpected: got %h want no token", result);
                end else begin
                    expv = exp_q.pop_front();
                    fc = cyc_q.pop_front();
                    if (result !== expv) begin failures++; $display("FAIL rnd_data: got %h want %h", result, expv); end
                    checks++;
                    if (cyc - fc < L) begin failures++; $display("FAIL rnd_latency: got %0d want >=%0d", cyc - fc, L); end
                end
            end
            if (exp_q.size() > L) begin
                checks++; failures++;
                $display("FAIL rnd_capacity: got %0d in flight want <=%0d", exp_q.size(), L);
            end
            prev_stall = result_valid && !result_ready;
            prev_res = result;
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_drain: got %0d left want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_join();
        test_backpressure();
        test_overflow();
        test_midreset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
